// File: rtl/lcd_reader.sv
// Read-side HD44780 bus sequencer: a single data read (RS=1) or a busy-flag poll
// (RS=0) repeated until BF clears or the poll limit is reached.
module lcd_reader #(
  parameter int T_AS     = 6,
  parameter int T_PW     = 25,
  parameter int T_AH     = 2,
  parameter int T_REC    = 100,
  parameter int POLL_MAX = 4000
) (
  input  logic       clk_en,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] q,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_d
);

  // Handshake: start is sampled only while busy=0 (including the done cycle);
  // done is a one-cycle pulse and q is valid whenever done is high.

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, RECOVER} state_t;

  localparam logic [15:0] AS_LAST   = 16'(T_AS - 1);
  localparam logic [15:0] PW_LAST   = 16'(T_PW - 1);
  localparam logic [15:0] AH_LAST   = 16'(T_AH - 1);
  localparam logic [15:0] REC_LAST  = 16'(T_REC - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] poll_cnt, poll_nxt;
  logic        mode_q, mode_nxt;
  logic [7:0]  q_nxt;
  logic        rs_nxt, rw_nxt, e_nxt, busy_nxt, done_nxt, timeout_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    poll_nxt    = poll_cnt;
    mode_nxt    = mode_q;
    q_nxt       = q;
    rs_nxt      = lcd_rs;
    rw_nxt      = lcd_rw;
    e_nxt       = lcd_e;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = 16'd0;
        rs_nxt   = 1'b0;
        rw_nxt   = 1'b0;
        e_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          mode_nxt  = mode;
          rs_nxt    = mode;
          rw_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          poll_nxt  = 16'd0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == AS_LAST) begin
          cnt_nxt   = 16'd0;
          e_nxt     = 1'b1;
          state_nxt = EHIGH;
        end
      end
      EHIGH: begin
        // The bus is captured only on the last E-high cycle.
        if (cnt == PW_LAST) begin
          cnt_nxt   = 16'd0;
          q_nxt     = lcd_d;
          e_nxt     = 1'b0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == AH_LAST) begin
          cnt_nxt   = 16'd0;
          rs_nxt    = 1'b0;
          rw_nxt    = 1'b0;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt == REC_LAST) begin
          cnt_nxt = 16'd0;
          if (mode_q || !q[7]) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else if (poll_cnt == POLL_LAST) begin
            done_nxt    = 1'b1;
            timeout_nxt = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
          end else begin
            poll_nxt  = poll_cnt + 16'd1;
            rs_nxt    = 1'b0;
            rw_nxt    = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
        rs_nxt    = 1'b0;
        rw_nxt    = 1'b0;
        e_nxt     = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      poll_cnt <= 16'd0;
      mode_q   <= 1'b0;
      q        <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_e    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      poll_cnt <= poll_nxt;
      mode_q   <= mode_nxt;
      q        <= q_nxt;
      lcd_rs   <= rs_nxt;
      lcd_rw   <= rw_nxt;
      lcd_e    <= e_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: directed reads and polls, a done/response scoreboard,
// and an LCD bus model that presents one byte per E window.
module tb_lcd_reader;

  localparam int T_AS = 6;
  localparam int T_PW = 25;
  localparam int T_AH = 2;
  localparam int T_REC = 100;
  localparam int POLL_MAX = 4;
  localparam int L = T_AS + T_PW + T_AH + T_REC;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic       busy, done, timeout;
  logic [7:0] q;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_d = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] bus_q[$];
  int         rise_q[$];
  int         e_cnt = 0;

  lcd_reader #(.T_AS(T_AS), .T_PW(T_PW), .T_AH(T_AH), .T_REC(T_REC), .POLL_MAX(POLL_MAX)) dut (
    .clk_en(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .timeout(timeout), .q(q),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  // clock / reset-independent cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: pops one expected response per done pulse
  logic [8:0] mon_exp;
  int         mon_cyc;
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("done_q", 32'(q), 32'(mon_exp[7:0]));
        check("done_timeout", 32'(timeout), 32'(mon_exp[8]));
        check("done_cycle", 32'(cyc), 32'(mon_cyc));
      end
    end else if (timeout) begin
      check("stray_timeout", 32'(timeout), 32'd0);
    end
  end

  // LCD bus model and E-pulse monitor
  logic e_prev = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      e_cnt++;
      rise_q.push_back(cyc);
      rise_cyc = cyc;
      check("e_rw_high", 32'(lcd_rw), 32'd1);
    end
    if (!lcd_e && e_prev) begin
      if (rst_n) check("e_width", 32'(cyc - rise_cyc), 32'(T_PW));
      if (bus_q.size() > 1) void'(bus_q.pop_front());
    end
    e_prev = lcd_e;
    lcd_d = (bus_q.size() > 0) ? bus_q[0] : 8'h00;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_bus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input int n);
    logic [7:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    bus_q.delete();
    for (int i = 0; i < n; i++) bus_q.push_back(v[i]);
    rise_q.delete();
    tick();
    tick();
  endtask

  task automatic do_start(input logic m, output int n);
    start = 1'b1;
    mode = m;
    n = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_done(input logic to, input logic [7:0] val, input int at);
    exp_q.push_back({to, val});
    exp_cyc_q.push_back(at);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done within %0d cycles, required %0d pending", budget, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, e0;
    rst_n = 1'b0;
    start = 1'b1;
    mode  = 1'b1;

    // reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outs", 32'({q, lcd_rs, lcd_rw, lcd_e, busy, done, timeout}), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_reset_outs", 32'({q, lcd_rs, lcd_rw, lcd_e, busy, done, timeout}), 32'd0);
    end
    check("reset_no_e", 32'(e_cnt), 32'd0);

    // data read, bus changes to junk after the sample
    set_bus(8'h48, 8'hEE, 8'h00, 8'h00, 2);
    e0 = e_cnt;
    do_start(1'b1, n);
    expect_done(1'b0, 8'h48, n + L);
    check("data_rs_rw_busy", 32'({lcd_rs, lcd_rw, busy, lcd_e}), 32'b1110);
    mode = 1'b0;
    wait_until(n + T_AS - 1);
    check("data_e_before", 32'(lcd_e), 32'd0);
    wait_until(n + T_AS);
    check("data_e_rise", 32'(lcd_e), 32'd1);
    wait_until(n + T_AS + T_PW - 1);
    check("data_q_before_sample", 32'(q), 32'h00);
    wait_until(n + T_AS + T_PW);
    check("data_q_sample", 32'(q), 32'h48);
    check("data_e_fall", 32'(lcd_e), 32'd0);
    wait_until(n + T_AS + T_PW + T_AH - 1);
    check("data_rs_hold", 32'({lcd_rs, lcd_rw}), 32'b11);
    wait_until(n + T_AS + T_PW + T_AH);
    check("data_rs_release", 32'({lcd_rs, lcd_rw}), 32'b00);
    wait_until(n + L - 1);
    check("data_busy_before_done", 32'(busy), 32'd1);
    wait_done(200);
    check("data_busy_after", 32'(busy), 32'd0);
    check("data_e_pulses", 32'(e_cnt - e0), 32'd1);

    // poll, BF clear on first read
    set_bus(8'h05, 8'h00, 8'h00, 8'h00, 1);
    e0 = e_cnt;
    do_start(1'b0, n);
    expect_done(1'b0, 8'h05, n + L);
    check("poll_rs_rw", 32'({lcd_rs, lcd_rw}), 32'b01);
    wait_done(200);
    check("poll_e_pulses", 32'(e_cnt - e0), 32'd1);

    // poll busy three times, with ignored start pulses while busy
    set_bus(8'h80, 8'h80, 8'h80, 8'h12, 4);
    e0 = e_cnt;
    do_start(1'b0, n);
    expect_done(1'b0, 8'h12, n + 4 * L);
    wait_until(n + 50);
    do_start(1'b1, n2);
    wait_until(n + L + 20);
    do_start(1'b1, n2);
    wait_until(n + L + T_AS + 1);
    check("poll_rs_after_ignored_start", 32'({lcd_rs, lcd_rw, lcd_e}), 32'b011);
    wait_done(700);
    check("poll3_e_pulses", 32'(e_cnt - e0), 32'd4);
    check("poll3_rises", 32'(rise_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rise_q.size(); i++)
      check("poll3_rise_cycle", 32'(rise_q[i]), 32'(n + T_AS + i * L));

    // poll timeout with BF stuck high
    set_bus(8'hFF, 8'h00, 8'h00, 8'h00, 1);
    e0 = e_cnt;
    do_start(1'b0, n);
    expect_done(1'b1, 8'hFF, n + POLL_MAX * L);
    wait_done(700);
    check("timeout_e_pulses", 32'(e_cnt - e0), 32'(POLL_MAX));

    // start on the done cycle begins a new read immediately
    set_bus(8'h5A, 8'h03, 8'h00, 8'h00, 2);
    e0 = e_cnt;
    do_start(1'b1, n);
    expect_done(1'b0, 8'h5A, n + L);
    wait_until(n + L);
    check("b2b_done_seen", 32'(done), 32'd1);
    do_start(1'b0, n2);
    expect_done(1'b0, 8'h03, n2 + L);
    check("b2b_n2", 32'(n2), 32'(n + L + 1));
    check("b2b_restart", 32'({busy, lcd_rs, lcd_rw}), 32'b101);
    wait_done(300);
    check("b2b_e_pulses", 32'(e_cnt - e0), 32'd2);

    // reset during E-high: E drops at that edge, no done, q cleared
    set_bus(8'h77, 8'h00, 8'h00, 8'h00, 1);
    e0 = e_cnt;
    do_start(1'b1, n);
    wait_until(n + T_AS + 5);
    check("rst_mid_e_high", 32'(lcd_e), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_outs", 32'({q, lcd_rs, lcd_rw, lcd_e, busy, done, timeout}), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (200) tick();
    check("rst_mid_q_kept", 32'(q), 32'h00);
    check("rst_mid_e_pulses", 32'(e_cnt - e0), 32'd1);

    // normal operation after the aborted read
    set_bus(8'hC3, 8'h00, 8'h00, 8'h00, 1);
    do_start(1'b1, n);
    expect_done(1'b0, 8'hC3, n + L);
    wait_done(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
